// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: operand/result handshakes and external 32-bit adder hookup
interface wide_add_sequencer_if #(parameter int WORDS = 4);
  localparam int W = 32 * WORDS;
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, add_cin, add_cout;
  logic [W-1:0] a, b, result;
  logic [31:0] add_in1, add_in2, add_sum;
  modport slave (
    input in_valid, a, b, cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, result, cout, ovf, add_in1, add_in2, add_cin
  );
  modport master (
    output in_valid, a, b, cin, out_ready, add_sum, add_cout,
    input in_ready, out_valid, result, cout, ovf, add_in1, add_in2, add_cin
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds 32*WORDS-bit operands one slice per cycle through a shared 32-bit adder
module wide_add_sequencer #(parameter int WORDS = 4) (
  input logic clk,
  input logic rst_n,
  wide_add_sequencer_if.slave bus
);
  localparam int W = 32 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_result;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, r_ovf;
  logic w_accept, w_run, w_last;
  always_comb begin
    w_accept = r_state == IDLE && bus.in_valid;
    w_run = r_state == RUN;
    w_last = w_run && r_idx == IW'(WORDS - 1);
    w_next = w_accept ? RUN : w_last ? DONE : (r_state == DONE && bus.out_ready) ? IDLE : r_state;
    bus.in_ready = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.add_in1 = w_run ? r_a[{r_idx, 5'd0} +: 32] : '0;
    bus.add_in2 = w_run ? r_b[{r_idx, 5'd0} +: 32] : '0;
    bus.add_cin = w_run && r_carry;
    bus.result = r_result;
    bus.cout = r_cout;
    bus.ovf = r_ovf;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // cout/ovf are captured from the top slice so they stay frozen through DONE and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_result <= '0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.b;
      r_carry <= bus.cin;
      r_idx <= '0;
      r_result <= '0;
    end else if (w_run) begin
      r_result[{r_idx, 5'd0} +: 32] <= bus.add_sum;
      r_carry <= bus.add_cout;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= bus.add_cout;
        r_ovf <= (r_a[W-1] == r_b[W-1]) && (bus.add_sum[31] != r_a[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed vectors checked against a wide-arithmetic model every cycle
module tb_wide_add_sequencer;
  localparam int WORDS = 4;
  localparam int W = 32 * WORDS;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  wide_add_sequencer_if #(.WORDS(WORDS)) bus ();
  wide_add_sequencer #(.WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_in1} + {1'b0, bus.add_in2} + 33'(bus.add_cin);
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model state: what the sequencer must be doing, derived from handshakes and wide sums
  logic busy = 1'b0;
  int k = 0;
  logic [W-1:0] ea, eb, er, lr, sa, sb;
  logic ecin, ec, eo, lc, lo, sc, siv, sor, srst;
  logic signed [W:0] ss;
  logic [W:0] wsum;

  function automatic logic carry_into(input int j);
    logic [W:0] m, s;
    m = ((W+1)'(1) << (32 * j)) - 1'b1;
    s = ({1'b0, ea} & m) + ({1'b0, eb} & m) + (W+1)'(ecin);
    return s[32 * j];
  endfunction

  always @(posedge clk) begin
    srst = rst_n; siv = bus.in_valid; sor = bus.out_ready;
    sa = bus.a; sb = bus.b; sc = bus.cin;
    #1;
    if (!srst) begin
      busy = 1'b0; k = 0; lr = '0; lc = 1'b0; lo = 1'b0;
    end else if (!busy && siv) begin
      busy = 1'b1; k = 0; ea = sa; eb = sb; ecin = sc;
      wsum = {1'b0, ea} + {1'b0, eb} + (W+1)'(ecin);
      er = wsum[W-1:0]; ec = wsum[W];
      ss = $signed({ea[W-1], ea}) + $signed({eb[W-1], eb}) + $signed({{W{1'b0}}, ecin});
      eo = ss[W] != ss[W-1];
    end else if (busy && k == WORDS && sor) begin
      busy = 1'b0; lr = er; lc = ec; lo = eo;
    end else if (busy && k < WORDS) k++;
    if (rst_n) begin
      chk("m_in_ready", (W+1)'(bus.in_ready), (W+1)'(!busy));
      chk("m_out_valid", (W+1)'(bus.out_valid), (W+1)'(busy && k == WORDS));
      if (busy && k < WORDS) begin
        chk("m_add_in1", (W+1)'(bus.add_in1), (W+1)'(ea[32*k +: 32]));
        chk("m_add_in2", (W+1)'(bus.add_in2), (W+1)'(eb[32*k +: 32]));
        chk("m_add_cin", (W+1)'(bus.add_cin), (W+1)'(carry_into(k)));
      end else
        chk("m_add_idle", (W+1)'({bus.add_in1, bus.add_in2, bus.add_cin}), '0);
      if (!busy || k == WORDS) begin
        chk("m_result", (W+1)'(bus.result), (W+1)'(busy ? er : lr));
        chk("m_cout", (W+1)'(bus.cout), (W+1)'(busy ? ec : lc));
        chk("m_ovf", (W+1)'(bus.ovf), (W+1)'(busy ? eo : lo));
      end
    end
  end

  task automatic accept(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    int t;
    logic rdy;
    @(negedge clk);
    bus.a = aa; bus.b = bb; bus.cin = cc; bus.in_valid = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      rdy = bus.in_ready;
      t++;
    end while (!rdy && t < 50);
    chk("accept_seen", (W+1)'(rdy), (W+1)'(1));
  endtask

  task automatic wait_ov(input logic hold, output int cyc, output logic [WORDS-1:0] cins);
    cyc = 0; cins = '0;
    do begin
      @(negedge clk);
      if (cyc == 0) bus.in_valid = hold;
      if (cyc < WORDS) cins[cyc] = bus.add_cin;
      cyc++;
    end while (!bus.out_valid && cyc < 50);
    chk("out_valid_seen", (W+1)'(bus.out_valid), (W+1)'(1));
  endtask

  initial begin
    int cyc, n;
    logic [WORDS-1:0] cins;
    logic [W-1:0] r0, rr;
    logic c0, o0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
    chk("rst_out_valid", (W+1)'(bus.out_valid), '0);
    chk("rst_result", (W+1)'(bus.result), '0);
    rst_n = 1'b1;
    accept('0, '0, 1'b0);
    wait_ov(1'b0, cyc, cins);
    chk("zero_latency", (W+1)'(cyc - 1), (W+1)'(WORDS));
    chk("zero_result", (W+1)'({bus.cout, bus.ovf, bus.result}), '0);
    accept({W{1'b1}}, '0, 1'b1);
    wait_ov(1'b0, cyc, cins);
    chk("ripple_result", (W+1)'(bus.result), '0);
    chk("ripple_cout", (W+1)'(bus.cout), (W+1)'(1));
    chk("ripple_ovf", (W+1)'(bus.ovf), '0);
    chk("ripple_cins", (W+1)'(cins), (W+1)'(4'b1111));
    accept({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0);
    wait_ov(1'b0, cyc, cins);
    chk("ovf_result", (W+1)'(bus.result), (W+1)'({1'b1, {(W-1){1'b0}}}));
    chk("ovf_cout", (W+1)'(bus.cout), '0);
    chk("ovf_flag", (W+1)'(bus.ovf), (W+1)'(1));
    accept(128'd5, 128'd7, 1'b0);
    wait_ov(1'b1, cyc, cins);
    chk("b2b_first", (W+1)'(bus.result), (W+1)'(12));
    accept(128'h1_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000_0000_0000, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0; rr = '0;
    while (!bus.in_ready && n < 20) begin
      if (bus.out_valid) rr = bus.result;
      n++;
      @(negedge clk);
    end
    chk("b2b_second", (W+1)'(rr), (W+1)'(128'h2_0000_0000_0000_0000_0000_0000));
    chk("b2b_busy_len", (W+1)'(n), (W+1)'(WORDS + 1));
    bus.out_ready = 1'b0;
    accept({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0);
    wait_ov(1'b0, cyc, cins);
    chk("bp_result", (W+1)'({bus.cout, bus.result}), (W+1)'({1'b1, {W{1'b0}}}));
    chk("bp_ovf", (W+1)'(bus.ovf), (W+1)'(1));
    r0 = bus.result; c0 = bus.cout; o0 = bus.ovf;
    repeat (10) begin
      @(negedge clk);
      bus.a = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.b = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_valid = ~bus.in_valid;
      #1;
      chk("bp_hold", (W+1)'({bus.cout, bus.ovf, bus.result}), (W+1)'({c0, o0, r0}));
      chk("bp_in_ready", (W+1)'(bus.in_ready), '0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff", (W+1)'({bus.in_ready, bus.out_valid}), (W+1)'(2'b10));
    accept(128'd5, 128'd7, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_partial", (W+1)'(bus.result), (W+1)'(12));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", (W+1)'(bus.out_valid), '0);
    chk("rst_mid_result", (W+1)'(bus.result), '0);
    chk("rst_mid_in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
    @(negedge clk);
    rst_n = 1'b1;
    accept(128'd9, 128'd10, 1'b1);
    wait_ov(1'b0, cyc, cins);
    chk("post_rst_latency", (W+1)'(cyc - 1), (W+1)'(WORDS));
    chk("post_rst_result", (W+1)'(bus.result), (W+1)'(20));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
